// File: rtl/quad_decoder_if.sv
// Bundles the encoder pins, load/clear controls and decoder results into one
// port. master drives the encoder side and controls; slave is the decoder.
interface quad_decoder_if #(
  parameter int NBITS_COUNT = 4
);
  logic                   enc_a;
  logic                   enc_b;
  logic                   load;
  logic [NBITS_COUNT-1:0] data_in;
  logic                   clear_err;
  logic [NBITS_COUNT-1:0] count;
  logic                   step;
  logic                   dir;
  logic                   err;
  logic                   err_flag;

  modport master (
    output enc_a, enc_b, load, data_in, clear_err,
    input  count, step, dir, err, err_flag
  );

  modport slave (
    input  enc_a, enc_b, load, data_in, clear_err,
    output count, step, dir, err, err_flag
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: two-flop synchronizer, per-phase persistence filter,
// Gray-code step decode and a loadable wrapping position counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | FILT_CYCLES+3 cycles after reset; filter bypassed, prev tracks
//       | cur, step/err suppressed so the power-up phase is not a move
// RUN   | normal decode until the next reset
//
// Phase vectors are packed as {A, B}: bit 1 is phase A, bit 0 is phase B.
module quad_decoder #(
  parameter int NBITS_COUNT = 4,
  parameter int FILT_CYCLES = 3
) (
  input logic           clk_i,
  input logic           reset_i,
  quad_decoder_if.slave bus_if
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);
  localparam logic [4:0] INIT_LAST = 5'(FILT_CYCLES + 2);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [4:0]             init_cnt_q;

  logic [1:0]             meta_q;
  logic [1:0]             sync_q;
  logic [1:0]             filt_q;
  logic [1:0]             filt_d;
  logic [1:0][3:0]        fcnt_q;
  logic [1:0][3:0]        fcnt_d;

  logic [1:0]             prev_q;
  logic [1:0]             diff;
  logic                   legal_step;
  logic                   illegal_step;
  logic                   step_up;

  logic [NBITS_COUNT-1:0] count_q;
  logic [NBITS_COUNT-1:0] count_d;
  logic                   step_q;
  logic                   dir_q;
  logic                   err_q;
  logic                   err_flag_q;

  // Two-flop synchronizer for the asynchronous encoder phases.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {bus_if.enc_a, bus_if.enc_b};
      sync_q <= meta_q;
    end
  end

  // Persistence filter next-state: a phase follows its synced value only after
  // FILT_CYCLES consecutive mismatching cycles; any agreeing cycle restarts it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (state_q == S_INIT) begin
        filt_d[i] = sync_q[i];
      end else if (sync_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      filt_q <= 2'b00;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Transition classification between the filtered phases and their last value.
  always_comb begin
    diff         = filt_q ^ prev_q;
    legal_step   = (diff == 2'b01) || (diff == 2'b10);
    illegal_step = (diff == 2'b11);
    step_up      = 1'b0;
    case ({prev_q, filt_q})
      4'b00_10: step_up = 1'b1;
      4'b10_11: step_up = 1'b1;
      4'b11_01: step_up = 1'b1;
      4'b01_00: step_up = 1'b1;
      default:  step_up = 1'b0;
    endcase
  end

  // Position next-state: load overrides a step that resolves on the same edge.
  always_comb begin
    count_d = count_q;
    if (bus_if.load) begin
      count_d = bus_if.data_in;
    end else if ((state_q == S_RUN) && legal_step) begin
      if (step_up) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Sequencing FSM with registered decoder outputs and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_INIT;
      init_cnt_q <= 5'd0;
      prev_q     <= 2'b00;
      count_q    <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      prev_q  <= filt_q;
      count_q <= count_d;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q <= S_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + 5'd1;
          end
        end
        S_RUN: begin
          if (legal_step) begin
            step_q <= 1'b1;
            dir_q  <= step_up;
          end
          if (illegal_step) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
      // The flag is set while err is visible, so a clear in that cycle loses.
      if (err_q) begin
        err_flag_q <= 1'b1;
      end else if (bus_if.clear_err) begin
        err_flag_q <= 1'b0;
      end
    end
  end

  assign bus_if.count    = count_q;
  assign bus_if.step     = step_q;
  assign bus_if.dir      = dir_q;
  assign bus_if.err      = err_q;
  assign bus_if.err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: expected steps are queued as motion is driven
// and compared as step pulses appear.
module tb_quad_decoder;

  typedef struct packed {
    logic [3:0] count;
    logic       dir;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc_no;
  int   first_step_cyc;
  int   drive_cyc;
  int   err_seen;
  int   err_exp;
  exp_t exp_q[$];

  quad_decoder_if #(.NBITS_COUNT(4)) bus_if ();

  quad_decoder #(
    .NBITS_COUNT(4),
    .FILT_CYCLES(3)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; each step pulse is checked against the oldest expectation.
  task automatic cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc_no++;
      if (bus_if.step === 1'b1) begin
        if (first_step_cyc < 0) first_step_cyc = cyc_no;
        if (exp_q.size() == 0) begin
          chk("step_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("step_count", 32'(bus_if.count), 32'(e.count));
          chk("step_dir", 32'(bus_if.dir), 32'(e.dir));
        end
      end
      if (bus_if.err === 1'b1) err_seen++;
    end
  endtask

  task automatic set_enc(input logic a, input logic b);
    bus_if.enc_a = a;
    bus_if.enc_b = b;
  endtask

  task automatic move(input logic a, input logic b, input logic [3:0] c, input logic d);
    exp_t e;
    e.count = c;
    e.dir   = d;
    exp_q.push_back(e);
    set_enc(a, b);
    cyc(8);
  endtask

  task automatic do_load(input logic [3:0] v);
    bus_if.load    = 1'b1;
    bus_if.data_in = v;
    cyc(1);
    bus_if.load    = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc_no = 0; first_step_cyc = -1;
    err_seen = 0; err_exp = 0;
    reset = 1'b1;
    set_enc(1'b1, 1'b1);
    bus_if.load = 1'b0; bus_if.data_in = 4'd0; bus_if.clear_err = 1'b0;

    // Reset with both phases high; nothing may be counted during or after INIT.
    cyc(2);
    chk("reset_count", 32'(bus_if.count), 32'd0);
    chk("reset_dir", 32'(bus_if.dir), 32'd1);
    chk("reset_step", 32'(bus_if.step), 32'd0);
    chk("reset_err_flag", 32'(bus_if.err_flag), 32'd0);
    reset = 1'b0;
    cyc(12);
    chk("post_init_count", 32'(bus_if.count), 32'd0);
    chk("post_init_dir", 32'(bus_if.dir), 32'd1);

    // Reset again mid-operation with phases at 00 for the motion tests.
    set_enc(1'b0, 1'b0);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(12);
    chk("rerun_count", 32'(bus_if.count), 32'd0);

    // Forward motion; first pulse lands 5 edges after A's capture edge.
    first_step_cyc = -1;
    drive_cyc = cyc_no;
    move(1'b1, 1'b0, 4'd1, 1'b1);
    chk("first_step_latency", 32'(first_step_cyc - drive_cyc), 32'd6);
    move(1'b1, 1'b1, 4'd2, 1'b1);
    move(1'b0, 1'b1, 4'd3, 1'b1);
    move(1'b0, 1'b0, 4'd4, 1'b1);
    chk("fwd_count", 32'(bus_if.count), 32'd4);
    chk("fwd_pending", 32'(exp_q.size()), 32'd0);

    // Reverse with wrap below zero.
    do_load(4'd1);
    chk("load_one", 32'(bus_if.count), 32'd1);
    move(1'b0, 1'b1, 4'd0, 1'b0);
    move(1'b1, 1'b1, 4'd15, 1'b0);
    move(1'b1, 1'b0, 4'd14, 1'b0);
    chk("rev_count", 32'(bus_if.count), 32'd14);
    chk("rev_dir", 32'(bus_if.dir), 32'd0);

    // Two-cycle glitches on each phase are rejected.
    set_enc(1'b0, 1'b0); cyc(2); set_enc(1'b1, 1'b0); cyc(10);
    set_enc(1'b1, 1'b1); cyc(2); set_enc(1'b1, 1'b0); cyc(10);
    chk("glitch_count", 32'(bus_if.count), 32'd14);
    chk("glitch_pending", 32'(exp_q.size()), 32'd0);

    // Illegal jumps and the sticky flag.
    move(1'b0, 1'b0, 4'd13, 1'b0);
    err_exp++;
    set_enc(1'b1, 1'b1);
    cyc(8);
    chk("illegal_err_pulses", 32'(err_seen), 32'(err_exp));
    chk("illegal_count", 32'(bus_if.count), 32'd13);
    chk("illegal_dir", 32'(bus_if.dir), 32'd0);
    chk("err_flag_set", 32'(bus_if.err_flag), 32'd1);
    err_exp++;
    set_enc(1'b0, 1'b0);
    cyc(6);
    chk("second_err_visible", 32'(bus_if.err), 32'd1);
    bus_if.clear_err = 1'b1;
    cyc(1);
    bus_if.clear_err = 1'b0;
    chk("set_beats_clear", 32'(bus_if.err_flag), 32'd1);
    cyc(4);
    bus_if.clear_err = 1'b1;
    cyc(1);
    bus_if.clear_err = 1'b0;
    chk("err_flag_cleared", 32'(bus_if.err_flag), 32'd0);
    chk("total_err_pulses", 32'(err_seen), 32'(err_exp));

    // Load wins over a step resolving on the same edge; step/dir still report it.
    do_load(4'd7);
    chk("load_seven", 32'(bus_if.count), 32'd7);
    begin
      exp_t e;
      e.count = 4'd2;
      e.dir   = 1'b1;
      exp_q.push_back(e);
    end
    set_enc(1'b1, 1'b0);
    cyc(5);
    bus_if.load    = 1'b1;
    bus_if.data_in = 4'd2;
    cyc(1);
    bus_if.load    = 1'b0;
    chk("load_step_pulse", 32'(bus_if.step), 32'd1);
    cyc(3);
    move(1'b1, 1'b1, 4'd3, 1'b1);
    chk("after_load_step", 32'(bus_if.count), 32'd3);

    // Wrap upward from the top value.
    do_load(4'd15);
    move(1'b0, 1'b1, 4'd0, 1'b1);
    chk("wrap_up_count", 32'(bus_if.count), 32'd0);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    chk("final_err_pulses", 32'(err_seen), 32'(err_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
